// File: rtl/store_byte_merge_pkg.sv
// Shared types and constants for the store path into the word-organised data RAM.
package store_byte_merge_pkg;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned LANES  = WORD_W / BYTE_W;
   localparam int unsigned LANE_W = 2;

   localparam logic ST_WORD = 1'b0;
   localparam logic ST_BYTE = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WAIT  = 2'd2,
      S_WRITE = 2'd3
   } state_e;

endpackage

// File: rtl/store_byte_merge_byte_lane_merge.sv
// Replaces one little-endian byte lane of a word, keeping the other lanes.
module byte_lane_merge
   import store_byte_merge_pkg::*;
(
   input  logic [WORD_W-1:0] word_i,
   input  logic [BYTE_W-1:0] byte_i,
   input  logic [LANE_W-1:0] lane_i,
   output logic [WORD_W-1:0] merged_o
);

   always_comb begin
      merged_o = word_i;
      for (int unsigned k = 0; k < LANES; k++) begin
         if (lane_i == LANE_W'(k)) begin
            merged_o[k*BYTE_W +: BYTE_W] = byte_i;
         end
      end
   end

endmodule

// File: rtl/store_byte_merge.sv
// SW/SB store unit: word stores write directly, byte stores do read-merge-write
// against a synchronous-read RAM. One store in flight at a time.
module store_byte_merge
   import store_byte_merge_pkg::*;
#(
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              st_valid,
   output logic              st_ready,
   input  logic [31:0]       st_addr,
   input  logic [31:0]       st_data,
   input  logic              st_byte,
   output logic              st_done,
   output logic              st_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_re,
   input  logic [31:0]       mem_rdata,
   output logic              mem_we,
   output logic [31:0]       mem_wdata
);

   state_e              state_q,     state_d;
   logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
   logic                mem_re_q,    mem_re_d;
   logic                mem_we_q,    mem_we_d;
   logic [WORD_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                st_done_q,   st_done_d;
   logic                st_err_q,    st_err_d;
   logic [LANE_W-1:0]   lane_q,      lane_d;
   logic [BYTE_W-1:0]   bdata_q,     bdata_d;
   logic [WORD_W-1:0]   merged;
   logic                unused_addr_hi;

   // Address bits above the RAM depth are dropped; addresses wrap.
   assign unused_addr_hi = ^st_addr[WORD_W-1:ADDR_W+2];

   byte_lane_merge u_merge (
      .word_i   (mem_rdata),
      .byte_i   (bdata_q),
      .lane_i   (lane_q),
      .merged_o (merged)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         mem_addr_q  <= '0;
         mem_re_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_wdata_q <= '0;
         st_done_q   <= 1'b0;
         st_err_q    <= 1'b0;
         lane_q      <= '0;
         bdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         mem_addr_q  <= mem_addr_d;
         mem_re_q    <= mem_re_d;
         mem_we_q    <= mem_we_d;
         mem_wdata_q <= mem_wdata_d;
         st_done_q   <= st_done_d;
         st_err_q    <= st_err_d;
         lane_q      <= lane_d;
         bdata_q     <= bdata_d;
      end
   end

   // Next-state and registered-output decode; strobes default low each cycle.
   always_comb begin
      state_d     = state_q;
      mem_addr_d  = mem_addr_q;
      mem_re_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_wdata_d = mem_wdata_q;
      st_done_d   = 1'b0;
      st_err_d    = 1'b0;
      lane_d      = lane_q;
      bdata_d     = bdata_q;

      case (state_q)
         S_IDLE: begin
            if (st_valid) begin
               if (st_byte == ST_BYTE) begin
                  state_d    = S_READ;
                  mem_addr_d = st_addr[ADDR_W+1:2];
                  mem_re_d   = 1'b1;
                  lane_d     = st_addr[LANE_W-1:0];
                  bdata_d    = st_data[BYTE_W-1:0];
               end else if (st_addr[LANE_W-1:0] == '0) begin
                  state_d     = S_WRITE;
                  mem_addr_d  = st_addr[ADDR_W+1:2];
                  mem_we_d    = 1'b1;
                  mem_wdata_d = st_data;
                  st_done_d   = 1'b1;
               end else begin
                  st_err_d = 1'b1;
               end
            end
         end
         S_READ: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // Read data is valid this cycle; merge and launch the write.
            state_d     = S_WRITE;
            mem_we_d    = 1'b1;
            mem_wdata_d = merged;
            st_done_d   = 1'b1;
         end
         S_WRITE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign st_ready  = (state_q == S_IDLE);
   assign st_done   = st_done_q;
   assign st_err    = st_err_q;
   assign mem_addr  = mem_addr_q;
   assign mem_re    = mem_re_q;
   assign mem_we    = mem_we_q;
   assign mem_wdata = mem_wdata_q;

endmodule
